ahb3lite_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one AHB3-Lite slave port among MASTERS bus masters.

---
 rtl/ahb3lite_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_ahb3lite_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_rr_arbiter.sv
// Round-robin AHB3-Lite arbiter: grant changes only at arbitration points (burst end, idle, lock release).
// Grant lands one cycle after the arbitration point; HREADY=0 freezes grant, beat count and data-phase owner.
module ahb3lite_rr_arbiter #(
    parameter  int MASTERS        = 2,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [MASTERS-1:0] HBUSREQ,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HMASTLOCK,
    input  logic               HREADY,
    output logic [MASTERS-1:0] HGRANT,
    output logic [MW-1:0]      HMASTER,
    output logic [MW-1:0]      HMASTER_D,
    output logic               ARB_SWITCH
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BU_SINGLE = 3'b000,
        BU_INCR   = 3'b001,
        BU_WRAP4  = 3'b010,
        BU_INCR4  = 3'b011,
        BU_WRAP8  = 3'b100,
        BU_INCR8  = 3'b101,
        BU_WRAP16 = 3'b110,
        BU_INCR16 = 3'b111
    } hburst_e;

    logic [MW-1:0] r_hmaster;
    logic [MW-1:0] r_hmaster_d;
    logic          r_switch;
    logic [4:0]    r_cnt;

    logic [4:0]    w_len_m1;
    logic [4:0]    w_cnt_nxt;
    logic          w_fixed;
    logic          w_ap;
    logic [MW-1:0] w_next_master;
    logic          w_found;
    logic [MW:0]   w_sum;
    logic [MW-1:0] w_cand;

    always_comb begin
        w_len_m1 = 5'd0;
        case (HBURST)
            BU_WRAP4,  BU_INCR4:  w_len_m1 = 5'd3;
            BU_WRAP8,  BU_INCR8:  w_len_m1 = 5'd7;
            BU_WRAP16, BU_INCR16: w_len_m1 = 5'd15;
            default:              w_len_m1 = 5'd0;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (HTRANS == TR_NONSEQ) begin
            w_cnt_nxt = w_len_m1;
        end else if (HTRANS == TR_SEQ && r_cnt != 5'd0) begin
            w_cnt_nxt = r_cnt - 5'd1;
        end
    end

    assign w_fixed = (HBURST[2:1] != 2'b00);

    // BUSY matches none of the terms, so an owner pausing mid-burst never loses the bus.
    always_comb begin
        w_ap = 1'b0;
        if (HREADY && !HMASTLOCK) begin
            if (HTRANS == TR_IDLE)
                w_ap = 1'b1;
            else if (HTRANS == TR_NONSEQ && HBURST == BU_SINGLE)
                w_ap = 1'b1;
            else if (HTRANS == TR_SEQ && w_fixed && r_cnt == 5'd1)
                w_ap = 1'b1;
            else if (HBURST == BU_INCR && HTRANS[1] && !HBUSREQ[r_hmaster])
                w_ap = 1'b1;
        end
    end

    // Search owner+1 upward with wrap; the owner itself is the last candidate.
    always_comb begin
        w_next_master = r_hmaster;
        w_found       = 1'b0;
        w_sum         = '0;
        w_cand        = '0;
        for (int i = 1; i <= MASTERS; i++) begin
            w_sum = {1'b0, r_hmaster} + (MW+1)'(i);
            if (w_sum >= (MW+1)'(MASTERS))
                w_sum = w_sum - (MW+1)'(MASTERS);
            w_cand = w_sum[MW-1:0];
            if (!w_found && HBUSREQ[w_cand]) begin
                w_found       = 1'b1;
                w_next_master = w_cand;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hmaster   <= MW'(DEFAULT_MASTER);
            r_hmaster_d <= MW'(DEFAULT_MASTER);
            r_switch    <= 1'b0;
            r_cnt       <= 5'd0;
        end else begin
            r_switch <= 1'b0;
            if (HREADY) begin
                r_hmaster_d <= r_hmaster;
                r_cnt       <= w_cnt_nxt;
            end
            if (w_ap) begin
                r_hmaster <= w_next_master;
                r_switch  <= (w_next_master != r_hmaster);
            end
        end
    end

    always_comb begin
        HGRANT            = '0;
        HGRANT[r_hmaster] = 1'b1;
    end

    assign HMASTER    = r_hmaster;
    assign HMASTER_D  = r_hmaster_d;
    assign ARB_SWITCH = r_switch;

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(HGRANT));
`endif

endmodule

// File: tb/tb_ahb3lite_rr_arbiter.sv
// Directed bench: a 2-master arbiter (default 0) and a 4-master arbiter (default 2) share control stimulus.
module tb_ahb3lite_rr_arbiter;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011, INCR8 = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] breq2;
    logic [3:0] breq4;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       lock;
    logic       rdy;

    logic [1:0] grant2;
    logic       master2, master_d2, sw2;
    logic [3:0] grant4;
    logic [1:0] master4, master_d4;
    logic       sw4;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ahb3lite_rr_arbiter #(.MASTERS(2), .DEFAULT_MASTER(0)) u_dut2 (
        .HCLK(clk), .HRESET(rst), .HBUSREQ(breq2), .HTRANS(trans), .HBURST(burst),
        .HMASTLOCK(lock), .HREADY(rdy), .HGRANT(grant2), .HMASTER(master2),
        .HMASTER_D(master_d2), .ARB_SWITCH(sw2)
    );

    ahb3lite_rr_arbiter #(.MASTERS(4), .DEFAULT_MASTER(2)) u_dut4 (
        .HCLK(clk), .HRESET(rst), .HBUSREQ(breq4), .HTRANS(trans), .HBURST(burst),
        .HMASTLOCK(lock), .HREADY(rdy), .HGRANT(grant4), .HMASTER(master4),
        .HMASTER_D(master_d4), .ARB_SWITCH(sw4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [2:0] b, input logic [1:0] rq);
        trans = t;
        burst = b;
        breq2 = rq;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; breq2 = 2'b00; breq4 = 4'b0000;
        trans = IDLE; burst = SINGLE; lock = 1'b0; rdy = 1'b1;
        tick(); tick();
        chk("rst_grant2", grant2, 2'b01);
        chk("rst_master2", master2, 1'b0);
        chk("rst_master_d2", master_d2, 1'b0);
        chk("rst_switch2", sw2, 1'b0);
        chk("rst_grant4", grant4, 4'b0100);
        chk("rst_master4", master4, 2'd2);
        chk("rst_master_d4", master_d4, 2'd2);

        rst = 1'b0;
        tick();
        chk("park_grant", grant2, 2'b01);
        chk("park_switch", sw2, 1'b0);

        // Idle owner, M1 requests: grant moves next cycle
        drive(IDLE, SINGLE, 2'b10); tick();
        chk("idle_sw_grant", grant2, 2'b10);
        chk("idle_sw_master", master2, 1'b1);
        chk("idle_sw_pulse", sw2, 1'b1);
        chk("idle_sw_master_d", master_d2, 1'b0);
        tick();
        chk("hold_grant", grant2, 2'b10);
        chk("pulse_1cycle", sw2, 1'b0);
        chk("master_d_follow", master_d2, 1'b1);
        drive(IDLE, SINGLE, 2'b01); tick();
        chk("back_to_m0", grant2, 2'b01);

        // INCR4 by M0 with M1 requesting and a wait state on beat 2
        drive(NONSEQ, INCR4, 2'b11); tick();
        chk("incr4_b1", grant2, 2'b01);
        drive(SEQ, INCR4, 2'b11); rdy = 1'b0; tick();
        chk("incr4_wait", grant2, 2'b01);
        rdy = 1'b1; tick();
        chk("incr4_b2", grant2, 2'b01);
        tick();
        chk("incr4_b3", grant2, 2'b01);
        chk("incr4_b3_sw", sw2, 1'b0);
        tick();
        chk("incr4_b4_grant", grant2, 2'b10);
        chk("incr4_b4_sw", sw2, 1'b1);
        chk("incr4_b4_master_d", master_d2, 1'b0);
        drive(IDLE, SINGLE, 2'b11); tick();
        chk("rr_back_m0", grant2, 2'b01);
        chk("rr_master_d_lag", master_d2, 1'b1);

        // Locked idle cycles block switching despite requests
        lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lock_grant", grant2, 2'b01);
            chk("lock_sw", sw2, 1'b0);
        end
        lock = 1'b0; tick();
        chk("unlock_grant", grant2, 2'b10);
        chk("unlock_sw", sw2, 1'b1);

        // Undefined-length burst: held while owner requests, released when it drops
        drive(NONSEQ, INCR, 2'b11); tick();
        chk("incr_held", grant2, 2'b10);
        drive(SEQ, INCR, 2'b01); tick();
        chk("incr_released", grant2, 2'b01);
        chk("incr_released_sw", sw2, 1'b1);

        drive(BUSY, INCR, 2'b10); tick();
        chk("busy_no_ap", grant2, 2'b01);
        chk("busy_no_sw", sw2, 1'b0);
        drive(IDLE, SINGLE, 2'b10); tick();
        chk("to_m1", grant2, 2'b10);
        drive(NONSEQ, SINGLE, 2'b11); tick();
        chk("single_ap", grant2, 2'b01);

        // HREADY low at an idle cycle: no switch, data-phase owner frozen
        drive(IDLE, SINGLE, 2'b10); tick();
        chk("to_m1_again", grant2, 2'b10);
        drive(IDLE, SINGLE, 2'b01); rdy = 1'b0; tick();
        chk("wait_hold_grant", grant2, 2'b10);
        chk("wait_hold_master_d", master_d2, 1'b0);
        rdy = 1'b1; tick();
        chk("wait_release_grant", grant2, 2'b01);
        chk("wait_release_master_d", master_d2, 1'b1);
        drive(IDLE, SINGLE, 2'b10); tick();
        chk("pre_incr8", grant2, 2'b10);

        // Reset at beat 3 of an INCR8 owned by M1
        drive(NONSEQ, INCR8, 2'b11); tick();
        drive(SEQ, INCR8, 2'b11); tick(); tick();
        chk("incr8_b3", grant2, 2'b10);
        rst = 1'b1; tick();
        chk("midrst_grant", grant2, 2'b01);
        chk("midrst_master", master2, 1'b0);
        chk("midrst_master_d", master_d2, 1'b0);
        chk("midrst_sw", sw2, 1'b0);
        rst = 1'b0;
        drive(NONSEQ, INCR4, 2'b11); tick();
        chk("restart_b1", grant2, 2'b01);
        drive(SEQ, INCR4, 2'b11); tick(); tick();
        chk("restart_b3", grant2, 2'b01);
        tick();
        chk("restart_b4", grant2, 2'b10);
        chk("sw4_quiet", sw4, 1'b0);

        // Four masters: owner 3 wraps to 0, then 1, 2, and back to 0
        drive(IDLE, SINGLE, 2'b00);
        breq4 = 4'b1000; tick();
        chk("m4_to3", master4, 2'd3);
        chk("m4_to3_sw", sw4, 1'b1);
        breq4 = 4'b0111; tick();
        chk("m4_wrap0", grant4, 4'b0001);
        tick();
        chk("m4_rr1", grant4, 4'b0010);
        chk("m4_master_d", master_d4, 2'd0);
        tick();
        chk("m4_rr2", grant4, 4'b0100);
        tick();
        chk("m4_rr0", grant4, 4'b0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
